mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Slave-side responder for the en/wr/addr bus driven by the stimulus task.
//   Samples the bus on each rising clk edge and executes writes into a local
//   byte-wide register array. Returns read data with one cycle of latency.
//   Counts completed transactions and flags out-of-range accesses.
//   Sits at the far end of the bus as the bench's DUT-side memory model.
// PARAMETERS
//   AW     6    address width; matches the 6-bit addr bus
//   DW     8    data width of wdata/rdata
//   DEPTH  48   implemented entries; addr >= DEPTH is out of range (DEPTH <= 2**AW)
//   CNT_W  8    width of wr_count/rd_count
// PORTS
//   clk       in   1      25 MHz clock (40 ns period); all sampling on posedge
//   rst       in   1      asynchronous reset, active-high
//   en        in   1      transaction enable; bus is idle when 0
//   wr        in   1      1 = write, 0 = read; qualified by en
//   addr      in   AW     word address
//   wdata     in   DW     write data; sampled when en & wr
//   rdata     out  DW     read data; registered
//   rvalid    out  1      1-cycle pulse; rdata is valid
//   err       out  1      1-cycle pulse; previous access had addr >= DEPTH
//   wr_count  out  CNT_W  number of accepted in-range writes
//   rd_count  out  CNT_W  number of accepted in-range reads
// BEHAVIOUR
//   Reset (rst=1, async, any time):
//     - rdata=0, rvalid=0, err=0, wr_count=0, rd_count=0.
//     - All DEPTH array entries cleared to 0.
//     - A transaction in flight at reset is dropped; no rvalid or err follows.
//   Per posedge with rst=0, decode {en,wr} sampled at that edge:
//     en=0:
//       - No array change; rvalid<=0, err<=0; rdata holds its last value.
//     en=1, wr=1, addr<DEPTH:
//       - mem[addr]<=wdata; wr_count++; rvalid<=0; err<=0.
//     en=1, wr=0, addr<DEPTH:
//       - rdata<=mem[addr]; rvalid<=1; rd_count++; err<=0.
//     en=1, addr>=DEPTH (either direction):
//       - No array change; counters unchanged; err<=1.
//       - Read: rdata<=0, rvalid<=1. Write: rvalid<=0.
//   Timing:
//     - Read latency is 1 cycle: bus sampled at edge N -> rdata/rvalid valid
//       after edge N, i.e. observable throughout cycle N..N+1.
//     - Write-then-read of the same addr on consecutive edges returns the new
//       data (write committed at edge N, read samples the array at edge N+1).
//     - Back-to-back reads produce rvalid held high with rdata updating
//       every cycle; no idle cycle is required between transactions.
//   Counters saturate at 2**CNT_W-1 and do not wrap.
//   Stateless across transactions: no FSM state beyond registered outputs,
//   counters and array. X on en is treated as en=0 (no array update).
// TESTING
//   1) rst pulse mid-run -> all outputs 0 asynchronously; mem[12] reads 0 afterwards.
//   2) en=1,wr=1: addr=12 wdata=8'hA5, then addr=14 wdata=8'h3C; then read 12,14
//      -> rdata=A5 then 3C with rvalid high 2 cycles; wr_count=2, rd_count=2.
//   3) Full stim pattern (wr 12,14; rd 23,48; en=0 addr 56) -> read 23 gives 0
//      with rvalid=1; read 48 gives err=1, rdata=0, rvalid=1; addr 56 with en=0
//      gives no response; rd_count=1.
//   4) Write addr=47 8'hFF, read addr=47 on the next edge -> rdata=FF after 1 cycle.
//   5) Write addr=50 -> err=1 for one cycle, wr_count unchanged, no array change.
//   6) 300 in-range writes with CNT_W=8 -> wr_count stops at 255.

Source files
------------

// File: rtl/mem_responder.sv
// Slave-side memory responder for the en/wr/addr bus: byte-wide register array,
// one-cycle registered read data, saturating transaction counters and a range-error pulse.
module mem_responder #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int DEPTH = 48,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata,
    output logic             rvalid,
    output logic             err,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count
);

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [0:DEPTH-1];

    logic in_range;
    logic do_write;
    logic do_read;
    logic bad_access;

    // Range check is done one bit wider so DEPTH == 2**AW is still representable.
    always_comb begin
        in_range   = ({1'b0, addr} < DEPTH_LIM);
        do_write   = 1'b0;
        do_read    = 1'b0;
        bad_access = 1'b0;
        if (en) begin
            do_write   = wr && in_range;
            do_read    = !wr && in_range;
            bad_access = !in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            if (do_read) begin
                rdata  <= mem[addr];
                rvalid <= 1'b1;
            end else if (bad_access) begin
                err <= 1'b1;
                // Out-of-range reads still complete, returning zero data.
                if (!wr) begin
                    rdata  <= '0;
                    rvalid <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (do_write && (wr_count != '1)) begin
                wr_count <= wr_count + CNT_W'(1);
            end
            if (do_read && (rd_count != '1)) begin
                rd_count <= rd_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: linear bus steps with hand-computed expectations.
module tb_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rvalid;
    logic       err;
    logic [7:0] wr_count;
    logic [7:0] rd_count;

    int checks = 0;
    int errors = 0;

    mem_responder #(.AW(6), .DW(8), .DEPTH(48), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .err      (err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one bus cycle at the falling edge, then settle just after the rising edge.
    task automatic bus(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        en    = e;
        wr    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] erd, input logic erv,
                           input logic eerr, input logic [7:0] ewc, input logic [7:0] erc);
        chk({tag, ".rdata"},    32'(rdata),    32'(erd));
        chk({tag, ".rvalid"},   32'(rvalid),   32'(erv));
        chk({tag, ".err"},      32'(err),      32'(eerr));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(ewc));
        chk({tag, ".rd_count"}, 32'(rd_count), 32'(erc));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        #5;
        chk_out("reset", 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Two writes, then back-to-back reads
        bus(1'b1, 1'b1, 6'd12, 8'hA5);
        chk_out("wr12", 8'h00, 1'b0, 1'b0, 8'd1, 8'd0);
        bus(1'b1, 1'b1, 6'd14, 8'h3C);
        chk_out("wr14", 8'h00, 1'b0, 1'b0, 8'd2, 8'd0);
        bus(1'b1, 1'b0, 6'd12, 8'h00);
        chk_out("rd12", 8'hA5, 1'b1, 1'b0, 8'd2, 8'd1);
        bus(1'b1, 1'b0, 6'd14, 8'h00);
        chk_out("rd14", 8'h3C, 1'b1, 1'b0, 8'd2, 8'd2);

        // Unwritten entry, out-of-range read, idle cycle
        bus(1'b1, 1'b0, 6'd23, 8'h00);
        chk_out("rd23", 8'h00, 1'b1, 1'b0, 8'd2, 8'd3);
        bus(1'b1, 1'b0, 6'd48, 8'h00);
        chk_out("rd48", 8'h00, 1'b1, 1'b1, 8'd2, 8'd3);
        bus(1'b0, 1'b0, 6'd56, 8'h00);
        chk_out("idle56", 8'h00, 1'b0, 1'b0, 8'd2, 8'd3);

        // Write-then-read on consecutive edges at the top valid address
        bus(1'b1, 1'b1, 6'd47, 8'hFF);
        chk_out("wr47", 8'h00, 1'b0, 1'b0, 8'd3, 8'd3);
        bus(1'b1, 1'b0, 6'd47, 8'h00);
        chk_out("rd47", 8'hFF, 1'b1, 1'b0, 8'd3, 8'd4);

        // Out-of-range write must not alias into the array
        bus(1'b1, 1'b1, 6'd50, 8'h99);
        chk_out("wr50", 8'hFF, 1'b0, 1'b1, 8'd3, 8'd4);
        bus(1'b1, 1'b0, 6'd2, 8'h00);
        chk_out("rd2", 8'h00, 1'b1, 1'b0, 8'd3, 8'd5);
        bus(1'b0, 1'b0, 6'd0, 8'h00);
        chk_out("idle", 8'h00, 1'b0, 1'b0, 8'd3, 8'd5);

        // Asynchronous reset mid-cycle, with a write in flight while held
        bus(1'b1, 1'b0, 6'd12, 8'h00);
        chk_out("rd12b", 8'hA5, 1'b1, 1'b0, 8'd3, 8'd6);
        #9;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 6'd5; wdata = 8'h77;
        @(posedge clk);
        #1;
        chk_out("rst_drop", 8'h00, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        bus(1'b1, 1'b0, 6'd12, 8'h00);
        chk_out("rd12_post", 8'h00, 1'b1, 1'b0, 8'd0, 8'd1);
        bus(1'b1, 1'b0, 6'd5, 8'h00);
        chk_out("rd5_post", 8'h00, 1'b1, 1'b0, 8'd0, 8'd2);

        // 300 in-range writes: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            bus(1'b1, 1'b1, 6'(i % 48), 8'(i));
            if (i == 253) chk("wr_count_254", 32'(wr_count), 32'd254);
            if (i == 254) chk("wr_count_255", 32'(wr_count), 32'd255);
        end
        chk("wr_count_sat", 32'(wr_count), 32'd255);
        bus(1'b1, 1'b0, 6'd11, 8'h00);
        chk_out("rd11_last", 8'h2B, 1'b1, 1'b0, 8'd255, 8'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
